// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port arbiter with a pending-write scoreboard: two write-back requesters share one port.
// Grant is combinational and the write launches one cycle later; the loser of a both-valid cycle waits, and a WAW issue is refused.
module regfile_wb_arbiter #(
  parameter int NREG = 32,
  parameter int XLEN = 64,
  localparam int AW = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            issue_valid,
  input  logic [AW-1:0]   issue_rd,
  output logic            issue_ready,
  input  logic [AW-1:0]   rs1,
  input  logic [AW-1:0]   rs2,
  output logic            busy_rs1,
  output logic            busy_rs2,
  input  logic            req0_valid,
  input  logic [AW-1:0]   req0_rd,
  input  logic [XLEN-1:0] req0_data,
  output logic            req0_ready,
  input  logic            req1_valid,
  input  logic [AW-1:0]   req1_rd,
  input  logic [XLEN-1:0] req1_data,
  output logic            req1_ready,
  output logic            wen,
  output logic [AW-1:0]   waddr,
  output logic [XLEN-1:0] wdata,
  output logic            err
);

  logic [NREG-1:0] busy_q, busy_d;
  logic            rr_q, rr_d;
  logic            wen_q;
  logic [AW-1:0]   waddr_q;
  logic [XLEN-1:0] wdata_q;
  logic            err_q, err_d;

  logic            both_vld, grant0, grant1, grant_vld, issue_acc;
  logic [AW-1:0]   grant_rd;
  logic [XLEN-1:0] grant_data;

  // rr_q == 0 favours req0 when both requesters are valid
  assign both_vld   = req0_valid && req1_valid;
  assign grant0     = req0_valid && !(both_vld && rr_q);
  assign grant1     = req1_valid && !(both_vld && !rr_q);
  assign grant_vld  = grant0 || grant1;
  assign grant_rd   = grant1 ? req1_rd : req0_rd;
  assign grant_data = grant1 ? req1_data : req0_data;

  assign req0_ready  = grant0;
  assign req1_ready  = grant1;
  assign issue_ready = !busy_q[issue_rd];
  assign issue_acc   = issue_valid && issue_ready;
  assign busy_rs1    = busy_q[rs1];
  assign busy_rs2    = busy_q[rs2];

  always_comb begin
    busy_d = busy_q;
    if (grant_vld)
      busy_d[grant_rd] = 1'b0;
    // set after clear so a same-cycle issue of the written rd stays pending
    if (issue_acc && issue_rd != '0)
      busy_d[issue_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  assign rr_d  = both_vld ? !rr_q : rr_q;
  assign err_d = err_q || (grant_vld && grant_rd != '0 && !busy_q[grant_rd]
                           && !(issue_acc && issue_rd == grant_rd));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy_q  <= '0;
      rr_q    <= 1'b0;
      wen_q   <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      busy_q <= busy_d;
      rr_q   <= rr_d;
      err_q  <= err_d;
      wen_q  <= grant_vld && grant_rd != '0;
      if (grant_vld) begin
        waddr_q <= grant_rd;
        wdata_q <= grant_data;
      end
    end
  end

  assign wen   = wen_q;
  assign waddr = waddr_q;
  assign wdata = wdata_q;
  assign err   = err_q;

endmodule
